tdm_demux4: RTL and testbench

- Receive-side counterpart of the 4:1 channel mux. Takes one time-division-multiplexed stream, where slot 0 is marked by frame_sync and slots 0..3 arrive in order, and splits it back into four registered channel outputs.
- Tracks frame alignment with a slot counter and lock state machine.
- Publishes all four channels together once per complete frame.
- Sits directly after the serial link or mux output, feeding four per-channel consumers.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_slot_ctr.sv | 24 ++
 rtl/tdm_demux4.sv | 114 +++++++++++
 tb/tb_tdm_demux4.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and types for the TDM mux/demux slice.
package tdm_pkg;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned SLOT_W = 2;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [SLOT_W-1:0] SLOT0 = SLOT_W'(0);
   localparam logic [SLOT_W-1:0] SLOT1 = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] SLOT2 = SLOT_W'(2);
   localparam logic [SLOT_W-1:0] SLOT3 = SLOT_W'(3);

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter: sync clear, load-to-1 and enable, wrapping 3 -> 0.
module tdm_slot_ctr
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load1,
   input  logic              en,
   output logic [SLOT_W-1:0] cnt
);

   // Priority: clear, then load, then count.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= SLOT0;
      end else if (load1) begin
         cnt <= SLOT1;
      end else if (en) begin
         cnt <= cnt + SLOT_W'(1);
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer with frame-sync lock tracking.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   input  logic         frame_sync,
   output logic [W-1:0] o0,
   output logic [W-1:0] o1,
   output logic [W-1:0] o2,
   output logic [W-1:0] o3,
   output logic         frame_valid,
   output logic         locked,
   output logic         sync_err
);

   state_t              state;
   state_t              state_nxt;
   logic [SLOT_W-1:0]   cnt;
   logic                ctr_clr;
   logic                ctr_load1;
   logic                ctr_en;
   logic [NUM_CH-2:0]   sh_we;
   logic                publish;
   logic                err;
   logic [W-1:0]        sh [NUM_CH-1];

   tdm_slot_ctr u_ctr (
      .clk   (clk),
      .rst   (rst),
      .clr   (ctr_clr),
      .load1 (ctr_load1),
      .en    (ctr_en),
      .cnt   (cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-beat controls; only valid beats act.
   always_comb begin
      state_nxt = state;
      ctr_clr   = 1'b0;
      ctr_load1 = 1'b0;
      ctr_en    = 1'b0;
      sh_we     = '0;
      publish   = 1'b0;
      err       = 1'b0;
      if (din_valid) begin
         if (state == HUNT) begin
            if (frame_sync) begin
               ctr_load1 = 1'b1;
               sh_we[0]  = 1'b1;
               state_nxt = LOCKED;
            end
         end else if (frame_sync) begin
            // Sync mid-frame resyncs in place rather than re-hunting.
            err       = (cnt != SLOT0);
            ctr_load1 = 1'b1;
            sh_we[0]  = 1'b1;
         end else if (cnt == SLOT0) begin
            err       = 1'b1;
            ctr_clr   = 1'b1;
            state_nxt = HUNT;
         end else begin
            ctr_en = 1'b1;
            case (cnt)
               SLOT1:   sh_we[1] = 1'b1;
               SLOT2:   sh_we[2] = 1'b1;
               default: publish  = 1'b1;
            endcase
         end
      end
   end

   // Shadow capture and whole-frame publish.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh[0]       <= '0;
         sh[1]       <= '0;
         sh[2]       <= '0;
         o0          <= '0;
         o1          <= '0;
         o2          <= '0;
         o3          <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         locked      <= 1'b0;
      end else begin
         frame_valid <= publish;
         sync_err    <= err;
         locked      <= (state_nxt == LOCKED);
         if (sh_we[0]) sh[0] <= din;
         if (sh_we[1]) sh[1] <= din;
         if (sh_we[2]) sh[2] <= din;
         if (publish) begin
            o0 <= sh[0];
            o1 <= sh[1];
            o2 <= sh[2];
            o3 <= din;
         end
      end
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed scoreboard bench for tdm_demux4 at W=4.
module tb_tdm_demux4;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         frame_sync;
   logic [W-1:0] o0, o1, o2, o3;
   logic         frame_valid, locked, sync_err;

   int vectors = 0;
   int miscompares = 0;
   int err_seen = 0;
   int fv_seen = 0;
   logic [4*W-1:0] exp_q[$];

   tdm_demux4 #(.W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .frame_sync  (frame_sync),
      .o0          (o0),
      .o1          (o1),
      .o2          (o2),
      .o3          (o3),
      .frame_valid (frame_valid),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic beat(input logic [W-1:0] d, input logic s);
      din        = d;
      frame_sync = s;
      din_valid  = 1'b1;
      @(posedge clk);
      #1;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic idle(input int n);
      din_valid  = 1'b0;
      frame_sync = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      frame_sync = 1'b0;
   endtask

   task automatic frame(input logic [W-1:0] a, b, c, d);
      exp_q.push_back({a, b, c, d});
      beat(a, 1'b1);
      beat(b, 1'b0);
      beat(c, 1'b0);
      beat(d, 1'b0);
   endtask

   // Monitor: pop an expected frame on every frame_valid pulse.
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_valid) begin
            fv_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_frame", 32'(1), 32'(0));
            end else begin
               check("frame_out", 32'({o0, o1, o2, o3}), 32'(exp_q.pop_front()));
            end
         end
         if (sync_err) begin
            err_seen++;
            check("err_and_fv_exclusive", 32'(frame_valid), 32'(0));
         end
      end
   end

   initial begin
      rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_outs", 32'({o0, o1, o2, o3}), 32'(0));
      check("rst_flags", 32'({frame_valid, locked, sync_err}), 32'(0));

      // Unsynced beats are discarded silently while hunting.
      beat(4'h1, 1'b0);
      beat(4'h2, 1'b0);
      beat(4'h3, 1'b0);
      check("hunt_locked", 32'(locked), 32'(0));

      // Basic frame.
      exp_q.push_back(16'hABCD);
      beat(4'hA, 1'b1);
      check("lock_rise", 32'(locked), 32'(1));
      beat(4'hB, 1'b0);
      beat(4'hC, 1'b0);
      beat(4'hD, 1'b0);
      check("basic_fv", 32'(frame_valid), 32'(1));
      idle(1);
      check("fv_one_cycle", 32'(frame_valid), 32'(0));
      check("basic_hold", 32'({o0, o1, o2, o3}), 32'(16'hABCD));

      // Gapped frame, frame_sync toggling during gaps must be ignored.
      exp_q.push_back(16'h5678);
      beat(4'h5, 1'b1);
      beat(4'h6, 1'b0);
      idle(2);
      check("gap_no_fv", 32'(frame_valid), 32'(0));
      beat(4'h7, 1'b0);
      beat(4'h8, 1'b0);
      check("gap_fv", 32'(frame_valid), 32'(1));

      // Early sync drops the partial frame and resyncs.
      beat(4'h1, 1'b1);
      beat(4'h2, 1'b0);
      beat(4'h7, 1'b1);
      check("early_err", 32'(sync_err), 32'(1));
      check("early_locked", 32'(locked), 32'(1));
      exp_q.push_back(16'h789A);
      beat(4'h8, 1'b0);
      check("early_err_pulse", 32'(sync_err), 32'(0));
      beat(4'h9, 1'b0);
      beat(4'hA, 1'b0);

      // Missing sync drops to HUNT and holds outputs; back-to-back relock.
      frame(4'h1, 4'h2, 4'h3, 4'h4);
      beat(4'h5, 1'b0);
      check("miss_err", 32'(sync_err), 32'(1));
      check("miss_unlocked", 32'(locked), 32'(0));
      check("miss_hold", 32'({o0, o1, o2, o3}), 32'(16'h1234));
      frame(4'h6, 4'h7, 4'h8, 4'h9);
      check("relock", 32'(locked), 32'(1));

      // Reset mid-frame.
      beat(4'h1, 1'b1);
      beat(4'h2, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_outs", 32'({o0, o1, o2, o3}), 32'(0));
      check("midrst_locked", 32'(locked), 32'(0));
      frame(4'hB, 4'hC, 4'hD, 4'hE);
      idle(2);

      check("frames_seen", 32'(fv_seen), 32'(6));
      check("errs_seen", 32'(err_seen), 32'(2));
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
